// File: rtl/pcie_rx_lane_deskew.sv
// Multi-lane PIPE receive deskew: per-lane FIFOs aligned on a common COM (K28.5)
// and released in lockstep to the PHY receive block.
module pcie_rx_lane_deskew #(
  parameter int unsigned MAX_NUM_LANES = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DESKEW_DEPTH  = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                en_i,
  input  logic [MAX_NUM_LANES-1:0]            lane_active_i,
  input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] pipe_data_i,
  input  logic [MAX_NUM_LANES-1:0]            pipe_data_valid_i,
  input  logic [4*MAX_NUM_LANES-1:0]          pipe_data_k_i,
  input  logic [2*MAX_NUM_LANES-1:0]          pipe_sync_header_i,
  output logic [MAX_NUM_LANES*DATA_WIDTH-1:0] pipe_data_o,
  output logic [MAX_NUM_LANES-1:0]            pipe_data_valid_o,
  output logic [4*MAX_NUM_LANES-1:0]          pipe_data_k_o,
  output logic [2*MAX_NUM_LANES-1:0]          pipe_sync_header_o,
  output logic                                aligned_o,
  output logic                                deskew_err_o,
  output logic [7:0]                          err_count_o
);
  localparam int unsigned NL = MAX_NUM_LANES;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = $clog2(DESKEW_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DW + 6;

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, ALIGNED = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [NL-1:0] active_q;
  logic [NL-1:0] empty_c, full_c, com_c, wr_req_c, wr_en_c, pop_c, rel_lane_c;
  logic          flush_c, release_c, err_c;
  logic          any_act_c, all_ne_c, all_com_c, any_com_c, ovf_c, loss_c, rel_c;
  logic [7:0]    err_count_d;

  logic [NL*DW-1:0] data_d;
  logic [4*NL-1:0]  k_d;
  logic [2*NL-1:0]  sh_d;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic [EW-1:0] mem_q [DESKEW_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fill;
    logic [EW-1:0] head;

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign fill        = wr_ptr_q - rd_ptr_q;
    assign empty_c[l]  = (fill == '0);
    assign full_c[l]   = (fill == PW'(DESKEW_DEPTH));
    assign com_c[l]    = ~empty_c[l] & head[DW] & (head[7:0] == 8'hBC);
    assign wr_req_c[l] = pipe_data_valid_i[l] & lane_active_i[l] & (state_q != IDLE);

    assign wr_ptr_d = flush_c ? '0 : wr_ptr_q + PW'(wr_en_c[l]);
    assign rd_ptr_d = flush_c ? '0 : rd_ptr_q + PW'(pop_c[l]);

    // Entry layout: {sync_header, k, data}
    always_ff @(posedge clk_i) begin
      if (wr_en_c[l]) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {pipe_sync_header_i[2*l +: 2], pipe_data_k_i[4*l +: 4],
                                    pipe_data_i[DW*l +: DW]};
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    assign data_d[DW*l +: DW] = rel_lane_c[l] ? head[DW-1:0]     : '0;
    assign k_d[4*l +: 4]      = rel_lane_c[l] ? head[DW+3:DW]    : '0;
    assign sh_d[2*l +: 2]     = rel_lane_c[l] ? head[DW+5:DW+4]  : '0;
  end

  assign any_act_c  = |lane_active_i;
  assign all_ne_c   = any_act_c && ((~empty_c & lane_active_i) == lane_active_i);
  assign all_com_c  = any_act_c && ((com_c & lane_active_i) == lane_active_i);
  assign any_com_c  = |(com_c & lane_active_i);
  assign ovf_c      = |(wr_req_c & full_c);
  // COM on some but not all heads of a common pop means the lanes slipped
  assign loss_c     = (state_q == ALIGNED) && all_ne_c && any_com_c && !all_com_c;
  assign rel_c      = (state_q == SEARCH) ? all_com_c : (all_ne_c && !loss_c);
  assign rel_lane_c = release_c ? lane_active_i : '0;

  always_comb begin
    state_d   = state_q;
    flush_c   = 1'b0;
    release_c = 1'b0;
    err_c     = 1'b0;
    wr_en_c   = '0;
    pop_c     = '0;
    if (!en_i) begin
      state_d = IDLE;
      flush_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          flush_c = 1'b1;
          if (any_act_c) state_d = SEARCH;
        end
        default: begin
          if (lane_active_i != active_q) begin
            flush_c = 1'b1;
            state_d = SEARCH;
          end else if (ovf_c || loss_c) begin
            err_c   = 1'b1;
            flush_c = 1'b1;
            state_d = SEARCH;
          end else begin
            wr_en_c = wr_req_c;
            if (rel_c) begin
              release_c = 1'b1;
              pop_c     = lane_active_i;
              state_d   = ALIGNED;
            end else if (state_q == SEARCH) begin
              pop_c = lane_active_i & ~empty_c & ~com_c;
            end
          end
        end
      endcase
    end
  end

  assign err_count_d = (err_c && (err_count_o != 8'hFF)) ? err_count_o + 8'd1 : err_count_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= IDLE;
      active_q           <= '0;
      pipe_data_o        <= '0;
      pipe_data_valid_o  <= '0;
      pipe_data_k_o      <= '0;
      pipe_sync_header_o <= '0;
      aligned_o          <= 1'b0;
      deskew_err_o       <= 1'b0;
      err_count_o        <= '0;
    end else begin
      state_q            <= state_d;
      active_q           <= lane_active_i;
      pipe_data_o        <= data_d;
      pipe_data_valid_o  <= rel_lane_c;
      pipe_data_k_o      <= k_d;
      pipe_sync_header_o <= sh_d;
      aligned_o          <= (state_d == ALIGNED);
      deskew_err_o       <= err_c;
      err_count_o        <= err_count_d;
    end
  end

endmodule

// File: tb/tb_pcie_rx_lane_deskew.sv
// Randomised bench for pcie_rx_lane_deskew against a queue-based lane model.
module tb_pcie_rx_lane_deskew;
  localparam int unsigned NL    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_ni, en;
  logic [NL-1:0]  act, pv;
  logic [NL*DW-1:0] pdata;
  logic [4*NL-1:0]  pk;
  logic [2*NL-1:0]  psh;
  logic [NL*DW-1:0] pipe_data_o;
  logic [NL-1:0]    pipe_data_valid_o;
  logic [4*NL-1:0]  pipe_data_k_o;
  logic [2*NL-1:0]  pipe_sync_header_o;
  logic             aligned_o, deskew_err_o;
  logic [7:0]       err_count_o;

  always #5 clk = ~clk;

  pcie_rx_lane_deskew #(.MAX_NUM_LANES(NL), .DATA_WIDTH(DW), .DESKEW_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .lane_active_i(act),
    .pipe_data_i(pdata), .pipe_data_valid_i(pv), .pipe_data_k_i(pk), .pipe_sync_header_i(psh),
    .pipe_data_o(pipe_data_o), .pipe_data_valid_o(pipe_data_valid_o),
    .pipe_data_k_o(pipe_data_k_o), .pipe_sync_header_o(pipe_sync_header_o),
    .aligned_o(aligned_o), .deskew_err_o(deskew_err_o), .err_count_o(err_count_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Lane traffic generator state: each lane replays one shared word stream
  int pos[NL];
  bit lane_on[NL];
  bit force_com[NL];
  int period;
  int drop_rate;

  // Reference model: one queue per lane plus a three-way mode
  typedef enum int {M_IDLE, M_SEARCH, M_ALIGNED} mstate_e;
  mstate_e        m_st;
  logic [NL-1:0]  m_act;
  logic [37:0]    mq[NL][$];
  logic [NL*DW-1:0] exp_data;
  logic [4*NL-1:0]  exp_k;
  logic [2*NL-1:0]  exp_sh;
  logic [NL-1:0]    exp_valid;
  logic             exp_aligned, exp_err;
  logic [7:0]       exp_cnt;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] word_of(input int n, input bit fc);
    logic [31:0] d;
    logic [3:0]  k;
    d = (32'(n) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    k = 4'(n >> 1);
    if (n % 7 == 3) begin
      d[7:0] = 8'hBC;
      k[0]   = 1'b0;
    end else if (k[0] && d[7:0] == 8'hBC) begin
      d[7:0] = 8'hBD;
    end
    if (fc || (period > 0 && n % period == 0)) begin
      d[7:0] = 8'hBC;
      k      = 4'b0001;
    end
    return {2'(n), k, d};
  endfunction

  function automatic bit is_com(input logic [37:0] e);
    return e[32] && (e[7:0] == 8'hBC);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE;
    m_act = '0;
    for (int l = 0; l < NL; l++) mq[l].delete();
    exp_data = '0; exp_k = '0; exp_sh = '0; exp_valid = '0;
    exp_aligned = 1'b0; exp_err = 1'b0; exp_cnt = '0;
  endtask

  task automatic model_step();
    bit flush, err, rel, ovf, loss;
    int nact, nne, ncom;
    logic [37:0] e;
    flush = 0; err = 0; rel = 0; ovf = 0; loss = 0;
    nact = 0; nne = 0; ncom = 0;
    exp_data = '0; exp_k = '0; exp_sh = '0; exp_valid = '0;
    if (!en) begin
      m_st = M_IDLE; flush = 1;
    end else if (m_st == M_IDLE) begin
      flush = 1;
      if (act != 0) m_st = M_SEARCH;
    end else if (act != m_act) begin
      flush = 1; m_st = M_SEARCH;
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (act[l]) begin
          nact++;
          if (mq[l].size() > 0) begin
            nne++;
            if (is_com(mq[l][0])) ncom++;
          end
          if (pv[l] && mq[l].size() == DEPTH) ovf = 1;
        end
      end
      if (m_st == M_SEARCH) rel = (nact > 0) && (ncom == nact);
      else if (nact > 0 && nne == nact) begin
        if (ncom > 0 && ncom < nact) loss = 1;
        else rel = 1;
      end
      if (ovf || loss) begin
        err = 1; flush = 1; m_st = M_SEARCH;
      end else begin
        for (int l = 0; l < NL; l++) begin
          if (act[l]) begin
            if (rel) begin
              e = mq[l].pop_front();
              exp_valid[l] = 1'b1;
              exp_data[l*DW +: DW] = e[31:0];
              exp_k[l*4 +: 4]      = e[35:32];
              exp_sh[l*2 +: 2]     = e[37:36];
            end else if (m_st == M_SEARCH && mq[l].size() > 0 && !is_com(mq[l][0])) begin
              void'(mq[l].pop_front());
            end
          end
        end
        for (int l = 0; l < NL; l++)
          if (act[l] && pv[l]) mq[l].push_back({psh[l*2 +: 2], pk[l*4 +: 4], pdata[l*DW +: DW]});
        if (rel) m_st = M_ALIGNED;
      end
    end
    m_act = act;
    if (flush) for (int l = 0; l < NL; l++) mq[l].delete();
    exp_aligned = (m_st == M_ALIGNED);
    exp_err = err;
    if (err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic drive();
    logic [37:0] w;
    for (int l = 0; l < NL; l++) begin
      pv[l] = 1'b0;
      pdata[l*DW +: DW] = $urandom;
      pk[l*4 +: 4]      = 4'($urandom);
      psh[l*2 +: 2]     = 2'($urandom);
      if (lane_on[l]) begin
        if (pos[l] < 0) pos[l]++;
        else if (drop_rate == 0 || $urandom_range(0, drop_rate - 1) != 0) begin
          w = word_of(pos[l], force_com[l]);
          pdata[l*DW +: DW] = w[31:0];
          pk[l*4 +: 4]      = w[35:32];
          psh[l*2 +: 2]     = w[37:36];
          pv[l] = 1'b1;
          pos[l]++;
        end
      end
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_step();
    #1;
    check_eq("aligned",   128'(aligned_o),          128'(exp_aligned));
    check_eq("err_pulse", 128'(deskew_err_o),       128'(exp_err));
    check_eq("err_count", 128'(err_count_o),        128'(exp_cnt));
    check_eq("valid",     128'(pipe_data_valid_o),  128'(exp_valid));
    check_eq("data",      pipe_data_o,              exp_data);
    check_eq("k",         128'(pipe_data_k_o),      128'(exp_k));
    check_eq("sync_hdr",  128'(pipe_sync_header_o), 128'(exp_sh));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_ni = 1'b0; en = 1'b0; act = '0; pv = '0; pdata = '0; pk = '0; psh = '0;
    period = 9; drop_rate = 0;
    for (int l = 0; l < NL; l++) begin pos[l] = -3; lane_on[l] = 1; force_com[l] = 0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data", pipe_data_o, '0);
    check_eq("rst_ctrl", 128'({aligned_o, deskew_err_o, err_count_o, pipe_data_valid_o,
                               pipe_data_k_o, pipe_sync_header_o}), '0);
    rst_ni = 1'b1;

    // Four lanes, no skew
    act = 4'hF; en = 1'b1;
    run(60);
    check_eq("noskew_aligned", 128'(aligned_o), 128'(1));
    check_eq("noskew_errcnt", 128'(err_count_o), 128'(0));

    // Lane 2 slips by one word while aligned
    pos[2] -= 1;
    run(40);
    check_eq("slip_realigned", 128'(aligned_o), 128'(1));
    check_eq("slip_errcnt", 128'(err_count_o), 128'(1));

    // Shrink the active mask while aligned
    act = 4'h3;
    run(40);
    check_eq("mask_aligned", 128'(aligned_o), 128'(1));
    check_eq("mask_errcnt", 128'(err_count_o), 128'(1));
    check_eq("mask_hi_valid", 128'(pipe_data_valid_o[3:2]), '0);
    check_eq("mask_hi_data", 128'(pipe_data_o[127:64]), '0);

    // Skew 0/1/3/2 words
    act = 4'hF; en = 1'b0;
    run(2);
    pos[0] = -3; pos[1] = -4; pos[2] = -6; pos[3] = -5;
    en = 1'b1;
    run(40);
    check_eq("skew_aligned", 128'(aligned_o), 128'(1));
    check_eq("skew_errcnt", 128'(err_count_o), 128'(1));

    // Skew of DEPTH words overflows the early lanes
    period = 16; en = 1'b0;
    run(2);
    pos[0] = -2; pos[1] = -2; pos[2] = -2; pos[3] = -10;
    en = 1'b1;
    run(11);
    check_eq("skew8_pulse", 128'(deskew_err_o), 128'(1));
    check_eq("skew8_errcnt", 128'(err_count_o), 128'(2));
    pos[3] = pos[0] - 3;
    run(40);
    check_eq("skew8_realigned", 128'(aligned_o), 128'(1));
    check_eq("skew8_errcnt_hold", 128'(err_count_o), 128'(2));

    // Randomised segments: masks, skews, drops, slips, enable toggles
    for (int s = 0; s < 10; s++) begin
      act = 4'($urandom_range(1, 15));
      period = $urandom_range(5, 14);
      drop_rate = ($urandom_range(0, 1) != 0) ? 0 : 24;
      en = ($urandom_range(0, 7) != 0);
      for (int l = 0; l < NL; l++) pos[l] = -int'($urandom_range(0, 9));
      run(60);
      if ($urandom_range(0, 1) != 0) pos[$urandom_range(0, NL - 1)] -= 1;
      en = 1'b1;
      run(60);
    end

    // Repeated overflows until the counter saturates
    drop_rate = 0; period = 9; act = 4'h3; en = 1'b1;
    lane_on[1] = 0; force_com[0] = 1; pos[0] = 0;
    run(2600);
    check_eq("sat_errcnt", 128'(err_count_o), 128'(8'hFF));

    // Asynchronous reset mid-cycle
    #3;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_data", pipe_data_o, '0);
    check_eq("arst_ctrl", 128'({aligned_o, deskew_err_o, err_count_o, pipe_data_valid_o,
                                pipe_data_k_o, pipe_sync_header_o}), '0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    en = 1'b0;
    run(1);
    act = 4'hF; en = 1'b1;
    for (int l = 0; l < NL; l++) begin pos[l] = -2; lane_on[l] = 1; force_com[l] = 0; end
    run(30);
    check_eq("post_rst_aligned", 128'(aligned_o), 128'(1));
    check_eq("post_rst_errcnt", 128'(err_count_o), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
